// File: rtl/mem_stage.sv
// Memory-access stage: issues data-cache requests, stalls until dhit, and holds load data until MEM/WB advances.
// Define MEM_STAGE_LLSC_EN to add LL/SC support (ll_i/sc_i ports plus a link register).
module mem_stage #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid_i,
  input  logic              memREN_i,
  input  logic              memWEN_i,
  input  logic [WORD_W-1:0] aluout_i,
  input  logic [WORD_W-1:0] storedata_i,
  input  logic              halt_i,
  input  logic              advance_i,
  input  logic              flush_i,
`ifdef MEM_STAGE_LLSC_EN
  input  logic              ll_i,
  input  logic              sc_i,
`endif
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmemload_o,
  output logic [WORD_W-1:0] aluout_o,
  output logic              mem_stall,
  output logic              halt_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] capture;
  logic              access;
  logic              issue;
  logic              complete;
  logic              sc_fail;

  assign access = valid_i & (memREN_i | memWEN_i);

`ifdef MEM_STAGE_LLSC_EN
  logic              link_vld;
  logic [WORD_W-1:0] link_addr;
  logic              is_sc;
  logic              sc_ok;

  assign is_sc   = valid_i & memWEN_i & sc_i;
  assign sc_ok   = link_vld & (link_addr == aluout_i);
  assign sc_fail = is_sc & ~sc_ok;
`else
  assign sc_fail = 1'b0;
`endif

  // A failed SC never touches the cache, so it completes in IDLE without stalling.
  assign issue    = access & ~flush_i & ~sc_fail;
  assign complete = (((state == IDLE) & issue) | (state == REQ)) & dhit;

  always_comb begin
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mem_stall  = 1'b0;
    dmemload_o = dmemload;
    case (state)
      IDLE: begin
        dmemREN   = issue & memREN_i;
        dmemWEN   = issue & memWEN_i;
        mem_stall = issue & ~dhit;
      end
      REQ: begin
        dmemREN   = valid_i & memREN_i;
        dmemWEN   = valid_i & memWEN_i;
        mem_stall = ~dhit;
      end
      DONE: begin
        dmemload_o = capture;
      end
      default: begin
        dmemREN = 1'b0;
      end
    endcase
  end

  assign dmemaddr  = aluout_i;
  assign dmemstore = storedata_i;
  assign halt_o    = halt_i & valid_i & ~mem_stall;

`ifdef MEM_STAGE_LLSC_EN
  assign aluout_o = is_sc ? {{(WORD_W-1){1'b0}}, sc_ok} : aluout_i;
`else
  assign aluout_o = aluout_i;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      capture <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue & ~dhit) begin
            state <= REQ;
          end else if (issue & dhit & ~advance_i) begin
            state   <= DONE;
            capture <= dmemload;
          end
        end
        REQ: begin
          // Flush is deliberately ignored here: the cache access must finish.
          if (dhit) begin
            if (advance_i) begin
              state <= IDLE;
            end else begin
              state   <= DONE;
              capture <= dmemload;
            end
          end
        end
        DONE: begin
          if (advance_i | flush_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STAGE_LLSC_EN
  // SC clears the link only when it leaves the stage, so aluout_o stays valid while held in DONE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_vld  <= 1'b0;
      link_addr <= '0;
    end else if (complete & memREN_i & ll_i) begin
      link_vld  <= 1'b1;
      link_addr <= aluout_i;
    end else if (complete & memWEN_i & ~sc_i & (link_addr == aluout_i)) begin
      link_vld <= 1'b0;
    end else if (is_sc & advance_i & ~mem_stall & ((state == REQ) | ~flush_i)) begin
      link_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives the datapath-side data-cache request (ren/wen/addr/store) and waits for dhit.
- Stalls the pipeline while an access is outstanding.
- Captures load data if the downstream register cannot advance in the hit cycle, then presents load data, halt and ALU result to MEM/WB.

Parameters:
WORD_W, 32, data/address width (word_t)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
valid_i  input  1  EX/MEM holds a live instruction
memREN_i  input  1  instruction is a load
memWEN_i  input  1  instruction is a store
aluout_i  input  WORD_W  effective address / ALU result
storedata_i  input  WORD_W  store data (rt value)
halt_i  input  1  instruction is halt
advance_i  input  1  MEM/WB register latches this cycle (its EN)
flush_i  input  1  squash current MEM instruction
dhit  input  1  cache access complete this cycle
dmemload  input  WORD_W  cache read data, valid with dhit
dmemREN  output  1  cache read request
dmemWEN  output  1  cache write request
dmemaddr  output  WORD_W  cache address = aluout_i
dmemstore  output  WORD_W  cache write data
dmemload_o  output  WORD_W  load data to MEM/WB
aluout_o  output  WORD_W  ALU result to MEM/WB (pass-through)
mem_stall  output  1  to hazard unit: freeze IF..MEM, bubble MEM/WB
halt_o  output  1  halt to MEM/WB, gated by completion

Behaviour:
- Clock and reset: one clock CLK, rising edge. nRST is asynchronous, active-low. Reset forces state IDLE, data capture register 0 and link register 0. With all inputs 0 after reset, every output is 0.
- access = valid_i & (memREN_i | memWEN_i).
- States: IDLE, REQ, DONE. The state register is the only sequential element other than the capture register and the optional link register.
- IDLE:
  - dmemREN = access & memREN_i; dmemWEN = access & memWEN_i.
  - mem_stall = access & ~dhit.
  - Transitions: ~access -> IDLE. access & dhit & advance_i -> IDLE (zero extra latency). access & dhit & ~advance_i -> DONE with capture <= dmemload. access & ~dhit -> REQ.
- REQ:
  - Request held stable: same ren/wen/addr/store.
  - mem_stall = ~dhit.
  - Transitions: dhit & advance_i -> IDLE. dhit & ~advance_i -> DONE with capture. ~dhit -> REQ.
- DONE:
  - No request issued; mem_stall = 0.
  - dmemload_o = capture register. In every other state dmemload_o = dmemload.
  - advance_i -> IDLE.
- Address, store data and ALU result: dmemaddr = aluout_i; dmemstore = storedata_i; aluout_o = aluout_i in all states.
- halt_o = halt_i & valid_i & ~mem_stall. Halt never reaches WB ahead of an outstanding access.
- flush_i:
  - In IDLE or DONE: next state IDLE, no request issued that cycle.
  - In REQ: ignored until dhit; the access completes, then state goes IDLE and the data is discarded by the flushed MEM/WB.
  - The hazard unit must not depend on flush aborting a cache access.
- Reset mid-REQ: state returns to IDLE immediately and the request drops. Cache reset is concurrent.
- Single-cycle hit plus advance: no state change, no stall bubble.

Optional Feature:
Macro: MEM_STAGE_LLSC_EN
- Adds inputs ll_i and sc_i, plus a link register of valid bit and WORD_W-bit address.
- LL (load with ll_i): on completion, link <= {1, aluout_i}.
- SC (store with sc_i):
  - Success requires link valid & link.addr == aluout_i. The stage performs the write normally; aluout_o = 1 on completion; link cleared.
  - Failure: no dmemWEN, no stall; aluout_o = 0; link cleared.
- Any other completed store whose address equals link.addr clears the link.
- Without the macro: ll_i/sc_i ports are absent, there is no link register, and SC is never decoded.

Test Plan:
- Load, addr 0x100, dhit same cycle, advance_i=1 -> dmemREN=1 one cycle, mem_stall=0, dmemload_o=0xDEADBEEF, state stays IDLE.
- Load, dhit after 3 cycles -> mem_stall high exactly 3 cycles; dmemREN/dmemaddr stable throughout; data passed the cycle dhit rises.
- Store 0x12345678 to 0x200, dhit on 2nd cycle, advance_i=0 for 2 more cycles -> DONE; dmemWEN drops after dhit; no second write observed.
- Load hit with advance_i=0, then dmemload changes to 0x0 -> dmemload_o holds 0xCAFEF00D until advance_i=1.
- nRST asserted while in REQ -> dmemREN/dmemWEN/mem_stall 0 asynchronously; next access starts cleanly from IDLE.
- LLSC_EN: LL 0x300, SC 0x300 -> write issued, aluout_o=1. Second SC 0x300 -> no write, aluout_o=0. LL 0x300, store 0x300, SC 0x300 -> fails.
